// File: rtl/instr_load_ctrl.sv
// instr_load_ctrl: loads a high-byte-first byte stream into the 256x16 instruction
// BRAM, then releases the CPU and serves its fetches with one-cycle latency.
module instr_load_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    input  logic        i_fetch_req,
    input  logic [7:0]  i_fetch_addr,
    output logic        o_fetch_valid,
    output logic [15:0] o_fetch_instr,
    output logic        o_bram_we,
    output logic [7:0]  o_bram_waddr,
    output logic [15:0] o_bram_wdata,
    output logic [7:0]  o_bram_raddr,
    input  logic [15:0] i_bram_rdata,
    output logic        o_loading,
    output logic        o_load_done,
    output logic        o_overflow,
    output logic        o_cpu_run,
    output logic [8:0]  o_instr_count
);

    localparam logic [15:0] END_WORD  = 16'hFFFF;
    localparam logic [15:0] FILL_WORD = 16'h0000;
    localparam logic [8:0]  MAX_COUNT = 9'd256;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRxHi  = 3'd1;
    localparam logic [2:0] StRxLo  = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StRun   = 3'd4;
    localparam logic [2:0] StError = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [8:0]  count_q, count_d;
    logic [15:0] word_q, word_d;
    logic        load_done_q, load_done_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        fetch_fill_q, fetch_fill_d;
    logic [15:0] instr_hold_q, instr_d;
    logic        is_term;

    assign is_term = (word_q == END_WORD);

    // Load sequencing: byte assembly, write decision and session restart.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_d      = word_q;
        load_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StRxHi;
                    count_d = '0;
                end
            end
            StRxHi: begin
                if (i_byte_valid) begin
                    word_d[15:8] = i_byte;
                    state_d      = StRxLo;
                end
            end
            StRxLo: begin
                if (i_byte_valid) begin
                    word_d[7:0] = i_byte;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (is_term) begin
                    state_d     = StRun;
                    load_done_d = 1'b1;
                end else if (count_q == MAX_COUNT) begin
                    // Saturate instead of wrapping onto address 0.
                    state_d = StError;
                end else begin
                    count_d = count_q + 9'd1;
                    state_d = StRxHi;
                end
            end
            StRun, StError: begin
                if (i_start) begin
                    state_d = StRxHi;
                    count_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Fetch pipeline: accept only in RUN; the fill flag travels with the request.
    always_comb begin
        fetch_valid_d = i_fetch_req && (state_q == StRun);
        fetch_fill_d  = ({1'b0, i_fetch_addr} >= count_q);
        if (fetch_valid_q) begin
            instr_d = fetch_fill_q ? FILL_WORD : i_bram_rdata;
        end else begin
            instr_d = instr_hold_q;
        end
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            count_q       <= '0;
            word_q        <= '0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_fill_q  <= 1'b0;
            instr_hold_q  <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            word_q        <= word_d;
            load_done_q   <= load_done_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fill_q  <= fetch_fill_d;
            instr_hold_q  <= instr_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        o_byte_ready  = (state_q == StRxHi) || (state_q == StRxLo);
        o_loading     = (state_q == StRxHi) || (state_q == StRxLo) || (state_q == StWrite);
        o_bram_we     = (state_q == StWrite) && !is_term && (count_q != MAX_COUNT);
        o_bram_waddr  = count_q[7:0];
        o_bram_wdata  = word_q;
        o_bram_raddr  = i_fetch_addr;
        o_fetch_valid = fetch_valid_q;
        o_fetch_instr = instr_d;
        o_load_done   = load_done_q;
        o_overflow    = (state_q == StError);
        o_cpu_run     = (state_q == StRun);
        o_instr_count = count_q;
    end

endmodule

// File: doc/instr_load_ctrl.md
# instr_load_ctrl

Sequences the 256×16 instruction BRAM. It has two jobs:
- **Load:** assemble a byte stream (high byte first) into 16-bit instructions and write them to consecutive BRAM addresses from 0 until a terminator word arrives.
- **Run:** hold the CPU stopped until the load completes, then serve CPU fetch requests through the BRAM read port with fixed one-cycle latency.

It sits between the program loader (UART/host byte source), the CPU fetch stage and the BRAM.

## Interface
- END_WORD, 16'hFFFF, terminator word; ends the load and is never written.
- FILL_WORD, 16'h0000, word returned for fetches at addresses ≥ loaded count.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  begin (or restart) a load session.
- i_byte_valid  in  1  byte source has a byte.
- i_byte  in  8  byte data.
- o_byte_ready  out  1  controller accepts a byte; transfer = valid & ready.
- i_fetch_req  in  1  CPU fetch request.
- i_fetch_addr  in  8  fetch address.
- o_fetch_valid  out  1  o_fetch_instr is valid.
- o_fetch_instr  out  16  fetched instruction.
- o_bram_we  out  1  BRAM write enable.
- o_bram_waddr  out  8  BRAM write address.
- o_bram_wdata  out  16  BRAM write data.
- o_bram_raddr  out  8  BRAM read address.
- i_bram_rdata  in  16  BRAM registered read data; valid one cycle after the address.
- o_loading  out  1  load session in progress.
- o_load_done  out  1  one-cycle pulse on entering RUN.
- o_overflow  out  1  load aborted: more than 256 words.
- o_cpu_run  out  1  CPU may execute.
- o_instr_count  out  9  number of words written (0–256).

## Operation
- **States:** IDLE, RX_HI, RX_LO, WRITE, RUN, ERROR.
- **IDLE:**
  - o_byte_ready=0.
  - i_start → RX_HI; count cleared to 0.
- **RX_HI:**
  - o_byte_ready=1.
  - On transfer, word[15:8]←i_byte → RX_LO.
- **RX_LO:**
  - o_byte_ready=1.
  - On transfer, word[7:0]←i_byte → WRITE.
- **WRITE:**
  - o_byte_ready=0.
  - word==END_WORD → RUN; no write; count unchanged.
  - else count==256 → ERROR; no write.
  - else o_bram_we=1, waddr=count[7:0], wdata=word; count+1 → RX_HI.
- **RUN:**
  - o_cpu_run=1.
  - Fetches are served.
  - i_start → RX_HI; count cleared.
- **ERROR:**
  - o_overflow=1; o_cpu_run=0.
  - i_start → RX_HI; count cleared; o_overflow cleared.
- i_start is ignored in RX_HI, RX_LO and WRITE.
- o_loading=1 in RX_HI, RX_LO and WRITE.
- **Fetch:**
  - o_bram_raddr=i_fetch_addr combinationally.
  - A request is accepted only when i_fetch_req=1 while state==RUN.
  - Accepted requests are registered, together with the flag (addr ≥ count).
  - Next cycle: o_fetch_valid=1; o_fetch_instr=FILL_WORD if the flag is set, else i_bram_rdata.
  - Requests outside RUN are dropped: o_fetch_valid=0 and o_fetch_instr holds its last value.
  - A request accepted in the last RUN cycle before a restart still completes.
- **Widths:**
  - count is 9 bits and saturates at 256 (overflow goes to ERROR, never wraps).
  - waddr uses count[7:0].

## Timing
- **Reset:**
  - state=IDLE.
  - count=0, word=0.
  - All outputs 0, including o_fetch_instr=0 and o_bram_raddr=i_fetch_addr.
- **Reset mid-operation:** takes effect immediately. The current WRITE cycle is not performed; the partial word is discarded.
- **Load throughput:** at least 3 cycles per word (2 byte transfers + 1 WRITE). Byte-source stalls extend RX_HI/RX_LO indefinitely.
- **BRAM write:** o_bram_we is high for exactly one cycle per word; the BRAM captures on the edge ending WRITE.
- **RUN entry:** in the cycle after the terminator's WRITE cycle, o_cpu_run rises and o_load_done pulses for 1 cycle.
- **Fetch:**
  - Latency is exactly 1 cycle.
  - Fully pipelined: back-to-back requests give valid on consecutive cycles.
- **Restart from RUN:** o_cpu_run falls in the cycle after i_start.
- **Read-during-write:** cannot occur; fetches are only accepted in RUN and writes only happen in WRITE.

## Test plan
- Reset: assert i_rst mid-cycle → all outputs 0 asynchronously, state IDLE, o_byte_ready=0.
- Normal load: i_start, bytes 12,34,AB,CD,FF,FF →
  - we pulses (addr 0, 1234) and (addr 1, ABCD).
  - o_instr_count=2, one o_load_done pulse, o_cpu_run=1.
  - No write for FFFF.
- Fetch:
  - Request addr 1 → next cycle valid, instr=ABCD.
  - Back-to-back addr 0 then addr 5 → 1234 then 0000 on consecutive cycles.
  - Request in IDLE → no valid.
- Overflow: 257 non-terminator words →
  - 256 we pulses, addresses 0..255.
  - ERROR with o_overflow=1, no 257th write, o_instr_count=256.
  - i_start clears o_overflow.
- Full load: 256 words then FFFF → RUN with count=256; fetch 255 returns the last word.
- Reset mid-load / restart:
  - i_rst during RX_LO → no we; count stays 0.
  - i_start in RUN → o_cpu_run falls next cycle, count=0, fetch requests ignored until the reload completes.
